// File: rtl/ascon_perm_dom_nshare_if.sv
// Handshake and data bundle between the masked Ascon permutation engine,
// its mode controller and the randomness source.
interface ascon_perm_dom_nshare_if #(
  parameter int NSHARES = 2
);
  localparam int SW     = 320 * NSHARES;
  localparam int RAND_W = 320 * NSHARES * (NSHARES - 1) / 2;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [SW-1:0]     state_in;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [RAND_W-1:0] randbits;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     state_out;
  logic              busy;

  modport master (
    output in_valid, mode, state_in, rnd_valid, randbits, out_ready,
    input  in_ready, rnd_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, mode, state_in, rnd_valid, randbits, out_ready,
    output in_ready, rnd_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/ascon_perm_dom_nshare.sv
// Iterative DOM-masked Ascon permutation with NSHARES Boolean shares.
// Each round takes two cycles: cross-domain products are registered in RS1, compressed in RS2.
module ascon_perm_dom_nshare #(
  parameter int NSHARES = 2
) (
  input logic                    clk,
  input logic                    RST,
  ascon_perm_dom_nshare_if.slave bus
);
  localparam int NPAIRS = NSHARES * (NSHARES - 1) / 2;
  localparam int SW     = 320 * NSHARES;

  typedef enum logic [1:0] {IDLE, RS1, RS2, DONE} fsm_t;

  fsm_t          fsm_reg;
  logic [SW-1:0] state_reg;
  logic [3:0]    round_reg;
  logic          in_ready_reg;
  logic          rnd_ready_reg;
  logic          out_valid_reg;
  logic          busy_reg;

  // Cross-domain registers: ij holds share i's term for pair (i<j), ji holds share j's.
  logic [319:0] cross_ij_reg  [NPAIRS];
  logic [319:0] cross_ji_reg  [NPAIRS];
  logic [319:0] cross_ij_next [NPAIRS];
  logic [319:0] cross_ji_next [NPAIRS];

  logic [4:0][63:0] aff [NSHARES];
  logic [4:0][63:0] na  [NSHARES];
  logic [4:0][63:0] bm  [NSHARES];
  logic [SW-1:0]    state_next;
  logic [7:0]       rc;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic int pair_idx(input int i, input int j);
    return i * NSHARES - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic logic [3:0] start_round(input logic [1:0] m);
    case (m)
      2'b01:   return 4'd4;
      2'b10:   return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  assign rc = {4'hF - round_reg, round_reg};

  // RS2 recomputes the affine layer from the unchanged state register, so only
  // the cross-domain terms need to be held across the round boundary.
  generate
    for (genvar gi = 0; gi < NSHARES; gi++) begin : g_share
      logic [4:0][63:0] x;
      logic [63:0]      x2c;
      logic [319:0]     acc;
      logic [4:0][63:0] y;
      logic [4:0][63:0] z;
      logic [4:0][63:0] lin;

      assign x   = state_reg[320*gi +: 320];
      assign x2c = (gi == 0) ? (x[2] ^ {56'h0, rc}) : x[2];

      assign aff[gi] = {x[4] ^ x[3], x[3], x2c ^ x[1], x[1], x[0] ^ x[4]};
      // chi computes x_k ^ (~x_{k+1} & x_{k+2}); the inversion lives in share 0 only.
      assign na[gi]  = {aff[gi][0], aff[gi][4], aff[gi][3], aff[gi][2], aff[gi][1]}
                       ^ {320{gi == 0}};
      assign bm[gi]  = {aff[gi][1], aff[gi][0], aff[gi][4], aff[gi][3], aff[gi][2]};

      always_comb begin
        acc = aff[gi] ^ (na[gi] & bm[gi]);
        for (int i = 0; i < NSHARES; i++) begin
          for (int j = i + 1; j < NSHARES; j++) begin
            if (i == gi) acc = acc ^ cross_ij_reg[pair_idx(i, j)];
            if (j == gi) acc = acc ^ cross_ji_reg[pair_idx(i, j)];
          end
        end
      end

      assign y = acc;
      assign z = {y[4], y[3] ^ y[2], y[2] ^ {64{gi == 0}}, y[1] ^ y[0], y[0] ^ y[4]};

      assign lin[0] = z[0] ^ rotr(z[0], 19) ^ rotr(z[0], 28);
      assign lin[1] = z[1] ^ rotr(z[1], 61) ^ rotr(z[1], 39);
      assign lin[2] = z[2] ^ rotr(z[2], 1)  ^ rotr(z[2], 6);
      assign lin[3] = z[3] ^ rotr(z[3], 10) ^ rotr(z[3], 17);
      assign lin[4] = z[4] ^ rotr(z[4], 7)  ^ rotr(z[4], 41);

      assign state_next[320*gi +: 320] = lin;
    end

    for (genvar gi = 0; gi < NSHARES; gi++) begin : g_pi
      for (genvar gj = gi + 1; gj < NSHARES; gj++) begin : g_pj
        localparam int P = gi * NSHARES - (gi * (gi + 1)) / 2 + (gj - gi - 1);
        logic [319:0] r;
        assign r = bus.randbits[320*P +: 320];
        assign cross_ij_next[P] = (na[gi] & bm[gj]) ^ r;
        assign cross_ji_next[P] = (na[gj] & bm[gi]) ^ r;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (RST) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      round_reg     <= '0;
      in_ready_reg  <= 1'b1;
      rnd_ready_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      for (int p = 0; p < NPAIRS; p++) begin
        cross_ij_reg[p] <= '0;
        cross_ji_reg[p] <= '0;
      end
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg    <= bus.state_in;
            round_reg    <= start_round(bus.mode);
            in_ready_reg <= 1'b0;
            if (bus.mode == 2'b11) begin
              fsm_reg       <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              fsm_reg       <= RS1;
              rnd_ready_reg <= 1'b1;
              busy_reg      <= 1'b1;
            end
          end
        end
        RS1: begin
          if (bus.rnd_valid) begin
            for (int p = 0; p < NPAIRS; p++) begin
              cross_ij_reg[p] <= cross_ij_next[p];
              cross_ji_reg[p] <= cross_ji_next[p];
            end
            fsm_reg       <= RS2;
            rnd_ready_reg <= 1'b0;
          end
        end
        RS2: begin
          state_reg <= state_next;
          if (round_reg == 4'd11) begin
            fsm_reg       <= DONE;
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end else begin
            round_reg     <= round_reg + 4'd1;
            fsm_reg       <= RS1;
            rnd_ready_reg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm_reg       <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.rnd_ready = rnd_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.state_out = state_reg;
endmodule

// File: tb/tb_ascon_perm_dom_nshare.sv
// Bench for the masked Ascon permutation: random share splits and randomness,
// checked against an unmasked table-lookup Ascon model.
module tb_ascon_perm_dom_nshare;
  localparam int NS = 3;
  localparam int SW = 320 * NS;
  localparam int RW = 320 * NS * (NS - 1) / 2;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  ascon_perm_dom_nshare_if #(.NSHARES(NS)) bus ();
  ascon_perm_dom_nshare #(.NSHARES(NS)) dut (.clk(clk), .RST(RST), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                            5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                            5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                            5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  logic [7:0] rcon [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                            8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  typedef struct {
    logic [1:0]   mode;
    logic [319:0] din;
    int           exp_lat;
    logic [319:0] exp_out;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  // Unmasked reference: constant addition, S-box by 5-bit table lookup per column, linear layer.
  function automatic logic [319:0] ascon_ref(input logic [319:0] s, input int nr);
    logic [63:0] x [5];
    logic [4:0]  col;
    logic [4:0]  o;
    for (int k = 0; k < 5; k++) x[k] = s[64*k +: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ rcon[r];
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = sbox[col];
        x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    return {x[4], x[3], x[2], x[1], x[0]};
  endfunction

  function automatic int rounds_of(input logic [1:0] m);
    case (m)
      2'b00:   return 12;
      2'b01:   return 8;
      2'b10:   return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [RW-1:0] rand_rw();
    logic [RW-1:0] v;
    for (int i = 0; i < RW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [SW-1:0] split(input logic [319:0] u);
    logic [SW-1:0] v;
    logic [319:0]  acc;
    acc = u;
    for (int s = 1; s < NS; s++) begin
      v[320*s +: 320] = rand320();
      acc = acc ^ v[320*s +: 320];
    end
    v[319:0] = acc;
    return v;
  endfunction

  function automatic logic [319:0] unshare(input logic [SW-1:0] v);
    logic [319:0] acc;
    acc = '0;
    for (int s = 0; s < NS; s++) acc = acc ^ v[320*s +: 320];
    return acc;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // One transaction, entered and left on a negedge. While busy, in_valid is held
  // high with junk state/mode to show it is ignored. rst_at >= 0 pulses RST in RS2
  // after that many randomness handshakes and aborts the run.
  task automatic run_perm(input logic [1:0] md, input logic [SW-1:0] sh_in,
                          input int stall_at, input int stall_len, input int hold,
                          input int rst_at, output int lat, output logic [SW-1:0] res,
                          output bit saw_rnd, output bit stable, output bit aborted);
    int hs;
    int stalled;
    bit done;
    lat = 0; res = '0; saw_rnd = 0; stable = 1; aborted = 0;
    hs = 0; stalled = 0; done = 0;
    chk_int("in_ready_before_accept", int'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.mode      = md;
    bus.state_in  = sh_in;
    bus.rnd_valid = 1'b1;
    bus.randbits  = rand_rw();
    bus.out_ready = 1'b0;
    @(posedge clk);
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.rnd_ready) saw_rnd = 1;
      if (bus.out_valid) begin
        done = 1;
        bus.in_valid = 1'b0;
      end else if (rst_at >= 0 && hs == rst_at && bus.busy && !bus.rnd_ready) begin
        bus.in_valid = 1'b0;
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        aborted = 1;
        done = 1;
      end else begin
        bus.in_valid = 1'b1;
        bus.mode     = 2'($urandom);
        bus.state_in = split(rand320());
        bus.randbits = rand_rw();
        if (bus.rnd_ready && hs == stall_at && stalled < stall_len) begin
          bus.rnd_valid = 1'b0;
          stalled++;
        end else begin
          bus.rnd_valid = 1'b1;
          if (bus.rnd_ready) hs++;
        end
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_valid_timeout: got no out_valid after %0d cycles required %0d", lat, 2 * rounds_of(md) + 1);
      bus.in_valid = 1'b0;
      RST = 1'b1;
      @(negedge clk);
      RST = 1'b0;
      return;
    end
    if (aborted) return;
    res = bus.state_out;
    repeat (hold) begin
      @(negedge clk);
      if (bus.state_out !== res || !bus.out_valid) stable = 0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk_int("back_to_idle", int'({bus.in_ready, bus.out_valid}), 2);
    $display("[TB] run mode=%0d latency=%0d out_x0=%h", md, lat, unshare(res) >> 256);
  endtask

  initial begin
    int           lat;
    logic [SW-1:0] sh;
    logic [SW-1:0] res;
    logic [SW-1:0] res_a [3];
    logic [319:0] iv_state;
    logic [319:0] u;
    bit           saw_rnd;
    bit           stable;
    bit           aborted;

    RST = 1'b1;
    bus.in_valid  = 1'b1;
    bus.mode      = 2'b00;
    bus.state_in  = '1;
    bus.rnd_valid = 1'b0;
    bus.randbits  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_int("rst_in_ready", int'(bus.in_ready), 1);
    chk_int("rst_rnd_ready", int'(bus.rnd_ready), 0);
    chk_int("rst_out_valid", int'(bus.out_valid), 0);
    chk_int("rst_busy", int'(bus.busy), 0);
    for (int s = 0; s < NS; s++) chk("rst_state_out", bus.state_out[320*s +: 320], '0);
    bus.in_valid = 1'b0;
    RST = 1'b0;
    @(negedge clk);

    iv_state = '0;
    iv_state[63:0] = 64'h80400c0600000000;
    vecs[0] = '{2'b00, 320'd0, 0, '0};
    vecs[1] = '{2'b01, iv_state, 0, '0};
    vecs[2] = '{2'b10, iv_state, 0, '0};
    vecs[3] = '{2'b11, rand320(), 0, '0};
    vecs[4] = '{2'b00, rand320(), 0, '0};
    vecs[5] = '{2'b01, rand320(), 0, '0};
    vecs[6] = '{2'b10, rand320(), 0, '0};
    for (int i = 0; i < 7; i++) begin
      vecs[i].exp_lat = (rounds_of(vecs[i].mode) == 0) ? 1 : 2 * rounds_of(vecs[i].mode) + 1;
      vecs[i].exp_out = ascon_ref(vecs[i].din, rounds_of(vecs[i].mode));
    end

    for (int i = 0; i < 7; i++) begin
      sh = split(vecs[i].din);
      run_perm(vecs[i].mode, sh, -1, 0, 0, -1, lat, res, saw_rnd, stable, aborted);
      chk_int("latency", lat, vecs[i].exp_lat);
      chk("unshared_out", unshare(res), vecs[i].exp_out);
      if (vecs[i].mode == 2'b11) begin
        for (int s = 0; s < NS; s++) chk("bypass_share", res[320*s +: 320], sh[320*s +: 320]);
        chk_int("bypass_rnd_ready_seen", int'(saw_rnd), 0);
      end
    end

    // Same zero input under three different share splits / randomness streams.
    for (int k = 0; k < 3; k++) begin
      run_perm(2'b00, split('0), -1, 0, 0, -1, lat, res_a[k], saw_rnd, stable, aborted);
      chk("split_unshared", unshare(res_a[k]), ascon_ref('0, 12));
    end
    chk_int("share0_differs_01", int'(res_a[0][319:0] != res_a[1][319:0]), 1);
    chk_int("share0_differs_12", int'(res_a[1][319:0] != res_a[2][319:0]), 1);

    // Randomness stall in round 3 plus output backpressure.
    run_perm(2'b00, split(iv_state), 3, 5, 3, -1, lat, res, saw_rnd, stable, aborted);
    chk_int("stall_latency", lat, 30);
    chk_int("stall_out_stable", int'(stable), 1);
    chk("stall_result", unshare(res), ascon_ref(iv_state, 12));

    // Reset in RS2 of round 7, then a fresh run.
    run_perm(2'b00, split(rand320()), -1, 0, 0, 8, lat, res, saw_rnd, stable, aborted);
    chk_int("rst_mid_aborted", int'(aborted), 1);
    chk_int("rst_mid_in_ready", int'(bus.in_ready), 1);
    chk_int("rst_mid_out_valid", int'(bus.out_valid), 0);
    chk_int("rst_mid_busy", int'(bus.busy), 0);
    for (int s = 0; s < NS; s++) chk("rst_mid_state_out", bus.state_out[320*s +: 320], '0);
    u = rand320();
    run_perm(2'b00, split(u), -1, 0, 0, -1, lat, res, saw_rnd, stable, aborted);
    chk_int("after_rst_latency", lat, 25);
    chk("after_rst_result", unshare(res), ascon_ref(u, 12));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
